regfile_multiport: RTL and testbench

//   Parametrised register file for the datapath: REG_N registers of DATA_W bits,
//   one write port and two independent read ports (A and B operand fetch).

---
 rtl/regfile_multiport.sv | 115 +++++++++++
 tb/tb_regfile_multiport.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// regfile_multiport: REG_N x DATA_W register file with one write port,
// two combinational read ports (A/B), per-register valid bits, a
// saturating write counter, a registered out-of-range write error pulse
// and a stepping scan port for the debug display chain.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   write/writenum/data_in write port
//   readnum_a/b -> data_out_a/b, valid_a/b   operand read ports
//   scan_step -> scan_idx, scan_data         debug scan port
//   wr_count              accepted writes since reset (saturating)
//   err_wr                one-cycle pulse after an out-of-range write
//
// Option: define WRITE_BYPASS_EN to make reads of the register being
// written this cycle return data_in (and valid=1) in the same cycle.
module regfile_multiport #(
   parameter int DATA_W = 16,
   parameter int REG_N  = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              write,
   input  logic [ADDR_W-1:0] writenum,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W-1:0] readnum_a,
   input  logic [ADDR_W-1:0] readnum_b,
   output logic [DATA_W-1:0] data_out_a,
   output logic [DATA_W-1:0] data_out_b,
   output logic              valid_a,
   output logic              valid_b,
   input  logic              scan_step,
   output logic [ADDR_W-1:0] scan_idx,
   output logic [DATA_W-1:0] scan_data,
   output logic [CNT_W-1:0]  wr_count,
   output logic              err_wr
);

   localparam logic [ADDR_W:0]   NREG = (ADDR_W+1)'(REG_N);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REG_N - 1);
   localparam bit                FULL = (REG_N == (1 << ADDR_W));

   logic [DATA_W-1:0] regs_q [REG_N];
   logic [REG_N-1:0]  valid_q;
   logic [ADDR_W-1:0] scan_q, scan_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              wr_ok;

   function automatic logic in_range(input logic [ADDR_W-1:0] idx);
      return FULL || ({1'b0, idx} < NREG);
   endfunction

   function automatic logic [DATA_W-1:0] rd_data(
      input logic [ADDR_W-1:0] idx);
      logic [DATA_W-1:0] v;
      v = '0;
      if (in_range(idx)) v = regs_q[idx];
`ifdef WRITE_BYPASS_EN
      if (wr_ok && idx == writenum) v = data_in;
`endif
      return v;
   endfunction

   function automatic logic rd_valid(input logic [ADDR_W-1:0] idx);
      logic v;
      v = 1'b0;
      if (in_range(idx)) v = valid_q[idx];
`ifdef WRITE_BYPASS_EN
      if (wr_ok && idx == writenum) v = 1'b1;
`endif
      return v;
   endfunction

   always_comb begin
      wr_ok  = write && in_range(writenum);
      err_d  = write && !in_range(writenum);
      cnt_d  = cnt_q;
      if (wr_ok && cnt_q != '1) cnt_d = cnt_q + 1'b1;
      scan_d = scan_q;
      if (scan_step) scan_d = (scan_q == LAST) ? '0 : scan_q + 1'b1;
   end

   always_comb begin
      data_out_a = rd_data(readnum_a);
      data_out_b = rd_data(readnum_b);
      valid_a    = rd_valid(readnum_a);
      valid_b    = rd_valid(readnum_b);
      scan_data  = rd_data(scan_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
         valid_q <= '0;
         scan_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (wr_ok) begin
            regs_q[writenum]  <= data_in;
            valid_q[writenum] <= 1'b1;
         end
         scan_q <= scan_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign scan_idx = scan_q;
   assign wr_count = cnt_q;
   assign err_wr   = err_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: two instances (8 regs / 8-bit count and
// 6 regs / 2-bit count) share stimulus and are checked against a model.
module tb_regfile_multiport;

   logic        clk = 1'b0;
   logic        reset, write, scan_step;
   logic [2:0]  writenum, readnum_a, readnum_b;
   logic [15:0] data_in;

   logic [15:0] a8, b8, sd8, a6, b6, sd6;
   logic        va8, vb8, va6, vb6, e8, e6;
   logic [2:0]  si8, si6;
   logic [7:0]  c8;
   logic [1:0]  c6;

   int n_vec = 0;
   int n_err = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   regfile_multiport dut8 (
      .clk(clk), .reset(reset), .write(write), .writenum(writenum),
      .data_in(data_in), .readnum_a(readnum_a), .readnum_b(readnum_b),
      .data_out_a(a8), .data_out_b(b8), .valid_a(va8), .valid_b(vb8),
      .scan_step(scan_step), .scan_idx(si8), .scan_data(sd8),
      .wr_count(c8), .err_wr(e8));

   regfile_multiport #(.REG_N(6), .CNT_W(2)) dut6 (
      .clk(clk), .reset(reset), .write(write), .writenum(writenum),
      .data_in(data_in), .readnum_a(readnum_a), .readnum_b(readnum_b),
      .data_out_a(a6), .data_out_b(b6), .valid_a(va6), .valid_b(vb6),
      .scan_step(scan_step), .scan_idx(si6), .scan_data(sd6),
      .wr_count(c6), .err_wr(e6));

   // behavioural model, index 0 = dut8, 1 = dut6
   int          nreg [2] = '{8, 6};
   int          cap  [2] = '{255, 3};
   logic [15:0] m_reg [2][8];
   bit          m_val [2][8];
   int          m_cnt [2];
   int          m_scan [2];
   bit          m_err [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            for (int i = 0; i < 8; i++) begin
               m_reg[d][i] = 16'h0;
               m_val[d][i] = 1'b0;
            end
            m_cnt[d] = 0; m_scan[d] = 0; m_err[d] = 1'b0;
         end else begin
            m_err[d] = write && (int'(writenum) >= nreg[d]);
            if (write && int'(writenum) < nreg[d]) begin
               m_reg[d][writenum] = data_in;
               m_val[d][writenum] = 1'b1;
               if (m_cnt[d] < cap[d]) m_cnt[d] = m_cnt[d] + 1;
            end
            if (scan_step) m_scan[d] = (m_scan[d] + 1) % nreg[d];
         end
      end
   end

   function automatic logic [15:0] e_data(input int d, input int idx);
      if (idx >= nreg[d]) return 16'h0;
`ifdef WRITE_BYPASS_EN
      if (write && idx == int'(writenum)) return data_in;
`endif
      return m_reg[d][idx];
   endfunction

   function automatic bit e_val(input int d, input int idx);
      if (idx >= nreg[d]) return 1'b0;
`ifdef WRITE_BYPASS_EN
      if (write && idx == int'(writenum)) return 1'b1;
`endif
      return m_val[d][idx];
   endfunction

   task automatic chk(input string nm, input int d,
                      input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %h want %h at %0t",
                  nm, d == 0 ? 8 : 6, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started && !reset) begin
         chk("data_a", 0, 32'(a8), 32'(e_data(0, int'(readnum_a))));
         chk("data_b", 0, 32'(b8), 32'(e_data(0, int'(readnum_b))));
         chk("valid_a", 0, 32'(va8), 32'(e_val(0, int'(readnum_a))));
         chk("valid_b", 0, 32'(vb8), 32'(e_val(0, int'(readnum_b))));
         chk("scan_idx", 0, 32'(si8), 32'(m_scan[0]));
         chk("scan_data", 0, 32'(sd8), 32'(e_data(0, m_scan[0])));
         chk("wr_count", 0, 32'(c8), 32'(m_cnt[0]));
         chk("err_wr", 0, 32'(e8), 32'(m_err[0]));
         chk("data_a", 1, 32'(a6), 32'(e_data(1, int'(readnum_a))));
         chk("data_b", 1, 32'(b6), 32'(e_data(1, int'(readnum_b))));
         chk("valid_a", 1, 32'(va6), 32'(e_val(1, int'(readnum_a))));
         chk("valid_b", 1, 32'(vb6), 32'(e_val(1, int'(readnum_b))));
         chk("scan_idx", 1, 32'(si6), 32'(m_scan[1]));
         chk("scan_data", 1, 32'(sd6), 32'(e_data(1, m_scan[1])));
         chk("wr_count", 1, 32'(c6), 32'(m_cnt[1]));
         chk("err_wr", 1, 32'(e6), 32'(m_err[1]));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] n, input logic [15:0] v);
      write = 1'b1; writenum = n; data_in = v;
      cyc();
      write = 1'b0;
   endtask

   logic [1:0] sat_exp [5];

   initial begin
      reset = 1'b1; write = 1'b0; scan_step = 1'b0;
      writenum = '0; readnum_a = '0; readnum_b = '0; data_in = '0;
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      cyc(); cyc();
      reset = 1'b0;
      started = 1'b1;

      // 1: everything cleared after reset
      for (int i = 0; i < 8; i++) begin
         readnum_a = 3'(i); readnum_b = 3'(7 - i);
         @(negedge clk);
         chk("rst_data_a", 0, 32'(a8), 32'h0);
         chk("rst_valid_b", 0, 32'(vb8), 32'h0);
         cyc();
      end
      chk("rst_scan", 0, 32'(si8), 32'h0);
      chk("rst_count", 0, 32'(c8), 32'h0);

      // 2: write R3 then read on both ports
      wr(3'd3, 16'h00A5);
      readnum_a = 3'd3; readnum_b = 3'd3;
      @(negedge clk);
      chk("r3_a", 0, 32'(a8), 32'h00A5);
      chk("r3_b", 0, 32'(b8), 32'h00A5);
      chk("r3_valid", 0, 32'(va8 & vb8), 32'h1);
      chk("r3_count", 0, 32'(c8), 32'h1);
      cyc();
      readnum_b = 3'd4;
      @(negedge clk);
      chk("r4_untouched", 0, 32'({vb8, b8}), 32'h0);
      cyc();

      // 3: writenum 7 is out of range for the 6-entry file
      wr(3'd7, 16'hFFFF);
      readnum_a = 3'd7;
      @(negedge clk);
      chk("oor_err", 1, 32'(e6), 32'h1);
      chk("oor_count", 1, 32'(c6), 32'h1);
      chk("oor_read", 1, 32'(a6), 32'h0);
      chk("inr_err", 0, 32'(e8), 32'h0);
      cyc();
      @(negedge clk);
      chk("oor_err_drop", 1, 32'(e6), 32'h0);
      cyc();

      // 4: same-cycle read of the register being written
      readnum_a = 3'd2;
      write = 1'b1; writenum = 3'd2; data_in = 16'h1234;
      @(negedge clk);
`ifdef WRITE_BYPASS_EN
      chk("bypass_same", 0, 32'(a8), 32'h1234);
`else
      chk("bypass_same", 0, 32'(a8), 32'h0);
`endif
      cyc();
      write = 1'b0;
      @(negedge clk);
      chk("bypass_next", 0, 32'(a8), 32'h1234);
      cyc();

      // 5: step the scan index around the file
      for (int k = 1; k <= 8; k++) begin
         scan_step = 1'b1;
         cyc();
         scan_step = 1'b0;
         @(negedge clk);
         chk("scan_step", 0, 32'(si8), 32'(k % 8));
      end
      scan_step = 1'b1;
      for (int k = 0; k < 5; k++) begin
         readnum_b = 3'(k);
         wr(3'(k + 1), 16'h1000 + 16'(k));
         write = 1'b0;
      end
      scan_step = 1'b0;
      cyc();

      // 6: counter saturation, then reset wins over a write
      reset = 1'b1; cyc(); reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         wr(3'(k), 16'hA000 + 16'(k));
         @(negedge clk);
         chk("sat_count", 1, 32'(c6), 32'(sat_exp[k]));
         chk("count", 0, 32'(c8), 32'(k + 1));
      end
      reset = 1'b1;
      wr(3'd1, 16'h5555);
      reset = 1'b0;
      readnum_a = 3'd1;
      @(negedge clk);
      chk("rst_wr_data", 0, 32'({va8, a8}), 32'h0);
      chk("rst_wr_count", 1, 32'(c6), 32'h0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
